// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the controller state encoding and architectural reset values.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    DRAIN   = 2'd2,
    DELIVER = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/event_counter.sv
// Wrapping event counter with increment enable.
// Generic enough for any performance counter in the core.
module event_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives a req/ack imem port and hands
// words to decode over valid/ready, absorbing redirects mid-access.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc4,
  input  logic            instr_ready,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_pend;
  logic [XLEN-1:0] target;
  logic            st_fetch;
  logic            st_drain;
  logic            st_deliver;
  logic            capture;
  logic            consume;

  assign target     = redirect_pc & ~XLEN'(3);
  assign st_fetch   = (state == FETCH);
  assign st_drain   = (state == DRAIN);
  assign st_deliver = (state == DELIVER);

  assign capture = st_fetch && imem_ack && !redirect_valid;
  assign consume = st_deliver && instr_ready;

  // Request side is decoded from state only, never from handshake inputs.
  assign imem_req    = st_fetch || st_drain;
  assign imem_addr   = pc;
  assign instr_valid = st_deliver;
  assign instr_pc4   = instr_pc + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= BOOT;
      pc      <= RESET_PC;
      pc_pend <= RESET_PC;
    end else begin
      unique case (1'b1)
        (state == BOOT): begin
          state <= FETCH;
        end
        st_fetch: begin
          if (imem_ack && redirect_valid) begin
            pc <= target;
          end else if (imem_ack) begin
            state <= DELIVER;
          end else if (redirect_valid) begin
            pc_pend <= target;
            state   <= DRAIN;
          end
        end
        st_drain: begin
          // The old access must complete; the latest target wins.
          if (imem_ack) begin
            pc    <= redirect_valid ? target : pc_pend;
            state <= FETCH;
          end else if (redirect_valid) begin
            pc_pend <= target;
          end
        end
        st_deliver: begin
          if (redirect_valid) begin
            pc    <= target;
            state <= FETCH;
          end else if (instr_ready) begin
            pc    <= instr_pc4;
            state <= FETCH;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr    <= NOP_INSTR;
      instr_pc <= RESET_PC;
    end else if (capture) begin
      instr    <= imem_rdata;
      instr_pc <= pc;
    end
  end

  event_counter #(
    .WIDTH (XLEN)
  ) u_fetch_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (consume),
    .count (fetch_count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: transaction-level model, per-cycle compare and
// directed scenarios with literal expectations.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0080;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc4;
  logic        instr_ready;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;
  int lat = 0;
  int mcnt = 0;
  int cyc = 0;

  fetch_ctrl #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc4      (instr_pc4),
    .instr_ready    (instr_ready),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a ^ 32'h1357_9BDF) + 32'h0000_0100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid && n < 40) begin
      tick();
      n++;
    end
    chk(name, {31'd0, instr_valid}, 32'd1);
  endtask

  // Memory: acks after `lat` extra request cycles, decided just after the edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (rst || !imem_req) begin
      imem_ack = 1'b0;
      mcnt = 0;
    end else if (mcnt >= lat) begin
      imem_ack = 1'b1;
      mcnt = 0;
    end else begin
      imem_ack = 1'b0;
      mcnt++;
    end
    imem_rdata = imem_ack ? word_at(imem_addr) : 32'hDEAD_BEEF;
  end

  // Model: either booting, holding a word, or with a fetch in flight
  // whose data may already be condemned by a redirect.
  logic        m_boot, m_hold, m_disc;
  logic [31:0] m_pc, m_tgt, h_instr, h_pc, m_cnt;
  logic [31:0] al;
  assign al = {redirect_pc[31:2], 2'b00};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_boot  <= 1'b1;
      m_hold  <= 1'b0;
      m_disc  <= 1'b0;
      m_pc    <= RST_PC;
      m_tgt   <= RST_PC;
      h_instr <= NOP;
      h_pc    <= RST_PC;
      m_cnt   <= 32'd0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (m_hold) begin
      if (instr_ready) m_cnt <= m_cnt + 32'd1;
      if (redirect_valid || instr_ready) begin
        m_hold <= 1'b0;
        m_pc   <= redirect_valid ? al : h_pc + 32'd4;
      end
    end else if (imem_ack) begin
      if (m_disc || redirect_valid) begin
        m_pc   <= redirect_valid ? al : m_tgt;
        m_disc <= 1'b0;
      end else begin
        m_hold  <= 1'b1;
        h_instr <= imem_rdata;
        h_pc    <= m_pc;
      end
    end else if (redirect_valid) begin
      m_disc <= 1'b1;
      m_tgt  <= al;
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("m_req", {31'd0, imem_req}, {31'd0, !m_boot && !m_hold});
      chk("m_valid", {31'd0, instr_valid}, {31'd0, m_hold});
      chk("m_count", fetch_count, m_cnt);
      if (imem_req || rst) chk("m_addr", imem_addr, m_pc);
      if (instr_valid || rst) begin
        chk("m_instr", instr, h_instr);
        chk("m_instr_pc", instr_pc, h_pc);
        chk("m_pc4", instr_pc4, h_pc + 32'd4);
      end
    end
  end

  task automatic chk_reset_vals();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_pc", instr_pc, RST_PC);
    chk("rst_pc4", instr_pc4, 32'h0000_0084);
    chk("rst_count", fetch_count, 32'd0);
  endtask

  initial begin
    int n;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    instr_ready = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) tick();
    chk_reset_vals();
    rst = 1'b0;

    // Zero-wait memory, ready high: one word every two cycles.
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk("s1_req", {31'd0, imem_req}, c % 2);
      chk("s1_valid", {31'd0, instr_valid}, 32'((c + 1) % 2));
      if (c % 2 == 1)
        chk("s1_addr", imem_addr, RST_PC + 32'(4 * ((c - 1) / 2)));
      else
        chk("s1_ipc", instr_pc, RST_PC + 32'(4 * (c / 2 - 1)));
    end
    chk("s1_count", fetch_count, 32'd3);
    instr_ready = 1'b0;
    lat = 3;

    // Consumer stalls 4 cycles on the 0x8C word.
    for (int c = 8; c <= 11; c++) begin
      tick();
      chk("s2_hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("s2_hold_instr", instr, word_at(32'h8C));
      chk("s2_hold_ipc", instr_pc, 32'h8C);
      chk("s2_no_req", {31'd0, imem_req}, 32'd0);
    end
    instr_ready = 1'b1;
    for (int c = 12; c <= 15; c++) begin
      tick();
      chk("s2_req", {31'd0, imem_req}, 32'd1);
      chk("s2_addr", imem_addr, 32'h90);
    end
    tick();
    chk("s2_ipc", instr_pc, 32'h90);
    chk("s2_count", fetch_count, 32'd4);
    instr_ready = 1'b0;

    // Two redirects while the 0x8 access is outstanding.
    wait_valid("s3_wait0");
    redirect_valid = 1'b1;
    redirect_pc = 32'h8;
    tick();
    redirect_valid = 1'b0;
    chk("s3_addr_r1", imem_addr, 32'h8);
    tick();
    chk("s3_addr_r2", imem_addr, 32'h8);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    chk("s3_addr_r3", imem_addr, 32'h8);
    chk("s3_req_r3", {31'd0, imem_req}, 32'd1);
    redirect_pc = 32'h200;
    tick();
    chk("s3_addr_r4", imem_addr, 32'h8);
    redirect_valid = 1'b0;
    tick();
    chk("s3_addr_r5", imem_addr, 32'h200);
    chk("s3_valid_r5", {31'd0, instr_valid}, 32'd0);
    wait_valid("s3_wait1");
    chk("s3_ipc", instr_pc, 32'h200);
    chk("s3_instr", instr, word_at(32'h200));

    // Misaligned redirect in DELIVER with ready low drops the word.
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    tick();
    redirect_valid = 1'b0;
    chk("s4_valid", {31'd0, instr_valid}, 32'd0);
    chk("s4_addr", imem_addr, 32'h40);
    chk("s4_count", fetch_count, 32'd4);
    lat = 0;

    // Redirect in the same cycle as ack.
    n = 0;
    while (!imem_ack && n < 20) begin
      tick();
      n++;
    end
    chk("s5_ack_seen", {31'd0, imem_ack}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    tick();
    redirect_valid = 1'b0;
    chk("s5_valid", {31'd0, instr_valid}, 32'd0);
    chk("s5_addr", imem_addr, 32'h300);
    wait_valid("s5_wait");
    chk("s5_ipc", instr_pc, 32'h300);

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    chk("s7_addr_top", imem_addr, 32'hFFFF_FFFC);
    instr_ready = 1'b1;
    tick();
    chk("s7_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("s7_pc4", instr_pc4, 32'h0);
    tick();
    chk("s7_addr_wrap", imem_addr, 32'h0);
    chk("s7_count", fetch_count, 32'd5);
    lat = 3;

    // Reset pulsed while draining.
    tick();
    tick();
    chk("s6_addr_r1", imem_addr, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc = 32'h500;
    tick();
    redirect_valid = 1'b0;
    chk("s6_drain_req", {31'd0, imem_req}, 32'd1);
    chk("s6_drain_addr", imem_addr, 32'h4);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals();
    tick();
    tick();
    rst = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h700;
    chk("s6_boot_req", {31'd0, imem_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    chk("s6_first_req", {31'd0, imem_req}, 32'd1);
    chk("s6_first_addr", imem_addr, RST_PC);
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
